// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/response port used by instruction_fetch_unit.
// The fetch unit is the master; the instruction memory is the slave.
interface instruction_fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic [WIDTH-1:0] addr;
    logic             ready;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end with a one-entry (address, instruction) buffer.
// Optional macro IFU_MISALIGN_CHECK_EN: trap unaligned PCs instead of fetching.
module instruction_fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] NOP_WORD = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          i_pc_address,
    input  logic                      i_flush,
    output logic [WIDTH-1:0]          o_instruction,
    output logic                      o_stall,
    output logic                      o_misaligned,
    output logic [15:0]               o_miss_count,
    instruction_fetch_unit_if.master  imem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] WORD_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

    state_t            state_q;
    logic              buf_valid_q;
    logic [WIDTH-3:0]  buf_addr_q;
    logic [WIDTH-1:0]  buf_data_q;
    logic [WIDTH-1:0]  req_addr_q;
    logic              drop_q;
    logic [15:0]       miss_count_q;
    logic [15:0]       miss_count_d;

    logic              hit_s;
    logic              misalign_s;
    logic              miss_s;

    // Buffer lookup, misalignment decode and saturating miss-count increment.
    always_comb begin
        hit_s = buf_valid_q && (buf_addr_q == i_pc_address[WIDTH-1:2]);
`ifdef IFU_MISALIGN_CHECK_EN
        misalign_s = (i_pc_address[1:0] != 2'b00);
`else
        misalign_s = 1'b0;
`endif
        miss_s = (state_q == ST_IDLE) && !misalign_s && !hit_s;
        if (miss_count_q == 16'hFFFF) begin
            miss_count_d = miss_count_q;
        end else begin
            miss_count_d = miss_count_q + 16'd1;
        end
    end

    // Core-facing outputs: a hit is presented with no added latency.
    always_comb begin
        o_instruction = NOP_WORD;
        o_stall       = 1'b1;
        o_misaligned  = 1'b0;
        if (reset) begin
            o_instruction = NOP_WORD;
            o_stall       = 1'b1;
            o_misaligned  = 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (misalign_s) begin
                o_misaligned = 1'b1;
                o_stall      = 1'b0;
            end else if (hit_s) begin
                o_instruction = buf_data_q;
                o_stall       = 1'b0;
            end else begin
                o_instruction = NOP_WORD;
                o_stall       = 1'b1;
            end
        end else begin
            o_stall = 1'b1;
        end
    end

    // Fetch FSM together with the buffer, drop flag and miss counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            buf_valid_q  <= 1'b0;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
            req_addr_q   <= '0;
            drop_q       <= 1'b0;
            miss_count_q <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_flush) begin
                        buf_valid_q <= 1'b0;
                    end
                    if (miss_s) begin
                        req_addr_q   <= i_pc_address & WORD_MASK;
                        miss_count_q <= miss_count_d;
                        state_q      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_flush) begin
                        buf_valid_q <= 1'b0;
                        drop_q      <= 1'b1;
                    end
                    if (imem.ready) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem.rvalid) begin
                        // A flush in the return cycle beats the fill.
                        if (drop_q || i_flush) begin
                            buf_valid_q <= 1'b0;
                        end else begin
                            buf_valid_q <= 1'b1;
                            buf_addr_q  <= req_addr_q[WIDTH-1:2];
                            buf_data_q  <= imem.rdata;
                        end
                        drop_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (i_flush) begin
                        buf_valid_q <= 1'b0;
                        drop_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem.req     = !reset && (state_q == ST_REQ);
    assign imem.addr    = reset ? '0 : req_addr_q;
    assign o_miss_count = miss_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed, table-driven bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

    localparam int          WIDTH = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] instr;
    logic        stall;
    logic        mis;
    logic [15:0] cnt;

    int n_vec = 0;
    int n_err = 0;

    instruction_fetch_unit_if #(.WIDTH(WIDTH)) imem_if ();

    instruction_fetch_unit #(.WIDTH(WIDTH), .NOP_WORD(NOP)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_pc_address  (pc),
        .i_flush       (flush),
        .o_instruction (instr),
        .o_stall       (stall),
        .o_misaligned  (mis),
        .o_miss_count  (cnt),
        .imem          (imem_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        flush;
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [31:0] e_instr;
        logic        e_stall;
        logic        e_req;
        logic [31:0] e_addr;
        logic [15:0] e_cnt;
        logic        e_mis;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [31:0] p, input logic fl,
                                input logic rdy, input logic rv, input logic [31:0] rd,
                                input logic [31:0] ei, input logic es, input logic er,
                                input logic [31:0] ea, input logic [15:0] ec, input logic em);
        vec_t v;
        v.rst = rst; v.pc = p; v.flush = fl; v.ready = rdy; v.rvalid = rv; v.rdata = rd;
        v.e_instr = ei; v.e_stall = es; v.e_req = er; v.e_addr = ea; v.e_cnt = ec; v.e_mis = em;
        return v;
    endfunction

    // Drive one cycle's inputs after the falling edge, then compare before the rising edge.
    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        reset          = v.rst;
        pc             = v.pc;
        flush          = v.flush;
        imem_if.ready  = v.ready;
        imem_if.rvalid = v.rvalid;
        imem_if.rdata  = v.rdata;
        #1;
        n_vec++;
        if (instr !== v.e_instr || stall !== v.e_stall || imem_if.req !== v.e_req ||
            imem_if.addr !== v.e_addr || cnt !== v.e_cnt || mis !== v.e_mis) begin
            n_err++;
            $display("FAIL %s: got instr=%h stall=%b req=%b addr=%h cnt=%0d mis=%b, want instr=%h stall=%b req=%b addr=%h cnt=%0d mis=%b",
                     tag, instr, stall, imem_if.req, imem_if.addr, cnt, mis,
                     v.e_instr, v.e_stall, v.e_req, v.e_addr, v.e_cnt, v.e_mis);
        end
    endtask

    vec_t tbl[$];

    initial begin
        reset = 1'b1; pc = 32'd0; flush = 1'b0;
        imem_if.ready = 1'b0; imem_if.rvalid = 1'b0; imem_if.rdata = 32'd0;

        // Main vectors: {rst, pc, flush, ready, rvalid, rdata, instr, stall, req, addr, cnt, mis}
        // Miss at 0x100 with immediate ready and rvalid, then five held-PC hits.
        tbl.push_back(mk(0, 32'h100, 0, 1, 0, 32'h0,         NOP,          1, 0, 32'h000, 16'd0, 0));
        tbl.push_back(mk(0, 32'h100, 0, 1, 0, 32'h0,         NOP,          1, 1, 32'h100, 16'd1, 0));
        tbl.push_back(mk(0, 32'h100, 0, 0, 1, 32'h00500093,  NOP,          1, 0, 32'h100, 16'd1, 0));
        tbl.push_back(mk(0, 32'h100, 0, 0, 0, 32'h0,         32'h00500093, 0, 0, 32'h100, 16'd1, 0));
        tbl.push_back(mk(0, 32'h100, 0, 0, 0, 32'h0,         32'h00500093, 0, 0, 32'h100, 16'd1, 0));
        tbl.push_back(mk(0, 32'h100, 0, 0, 1, 32'hBAD0BAD0,  32'h00500093, 0, 0, 32'h100, 16'd1, 0));
        tbl.push_back(mk(0, 32'h100, 0, 0, 0, 32'h0,         32'h00500093, 0, 0, 32'h100, 16'd1, 0));
        tbl.push_back(mk(0, 32'h100, 0, 0, 0, 32'h0,         32'h00500093, 0, 0, 32'h100, 16'd1, 0));
        // Miss at 0x104, ready withheld, rvalid one extra cycle late: 6 stall cycles.
        tbl.push_back(mk(0, 32'h104, 0, 0, 0, 32'h0,         NOP,          1, 0, 32'h100, 16'd1, 0));
        tbl.push_back(mk(0, 32'h104, 0, 0, 0, 32'h0,         NOP,          1, 1, 32'h104, 16'd2, 0));
        tbl.push_back(mk(0, 32'h104, 0, 0, 0, 32'h0,         NOP,          1, 1, 32'h104, 16'd2, 0));
        tbl.push_back(mk(0, 32'h104, 0, 1, 0, 32'h0,         NOP,          1, 1, 32'h104, 16'd2, 0));
        tbl.push_back(mk(0, 32'h104, 0, 0, 0, 32'h0,         NOP,          1, 0, 32'h104, 16'd2, 0));
        tbl.push_back(mk(0, 32'h104, 0, 0, 1, 32'h00A00113,  NOP,          1, 0, 32'h104, 16'd2, 0));
        tbl.push_back(mk(0, 32'h104, 0, 0, 0, 32'h0,         32'h00A00113, 0, 0, 32'h104, 16'd2, 0));
        // Flush in WAIT drops the returned word; the same PC re-misses.
        tbl.push_back(mk(0, 32'h108, 0, 0, 0, 32'h0,         NOP,          1, 0, 32'h104, 16'd2, 0));
        tbl.push_back(mk(0, 32'h108, 0, 1, 0, 32'h0,         NOP,          1, 1, 32'h108, 16'd3, 0));
        tbl.push_back(mk(0, 32'h108, 1, 0, 0, 32'h0,         NOP,          1, 0, 32'h108, 16'd3, 0));
        tbl.push_back(mk(0, 32'h108, 0, 0, 1, 32'h12345678,  NOP,          1, 0, 32'h108, 16'd3, 0));
        tbl.push_back(mk(0, 32'h108, 0, 0, 0, 32'h0,         NOP,          1, 0, 32'h108, 16'd3, 0));
        tbl.push_back(mk(0, 32'h108, 0, 0, 0, 32'h0,         NOP,          1, 1, 32'h108, 16'd4, 0));
        tbl.push_back(mk(0, 32'h108, 0, 1, 0, 32'h0,         NOP,          1, 1, 32'h108, 16'd4, 0));
        tbl.push_back(mk(0, 32'h108, 0, 0, 1, 32'h00108093,  NOP,          1, 0, 32'h108, 16'd4, 0));
        tbl.push_back(mk(0, 32'h108, 0, 0, 0, 32'h0,         32'h00108093, 0, 0, 32'h108, 16'd4, 0));
        // Flush coincident with rvalid; then flush during a hit still presents the hit.
        tbl.push_back(mk(0, 32'h10C, 0, 0, 0, 32'h0,         NOP,          1, 0, 32'h108, 16'd4, 0));
        tbl.push_back(mk(0, 32'h10C, 0, 1, 0, 32'h0,         NOP,          1, 1, 32'h10C, 16'd5, 0));
        tbl.push_back(mk(0, 32'h10C, 1, 0, 1, 32'hCAFEF00D,  NOP,          1, 0, 32'h10C, 16'd5, 0));
        tbl.push_back(mk(0, 32'h10C, 0, 0, 0, 32'h0,         NOP,          1, 0, 32'h10C, 16'd5, 0));
        tbl.push_back(mk(0, 32'h10C, 0, 1, 0, 32'h0,         NOP,          1, 1, 32'h10C, 16'd6, 0));
        tbl.push_back(mk(0, 32'h10C, 0, 0, 1, 32'h00C00193,  NOP,          1, 0, 32'h10C, 16'd6, 0));
        tbl.push_back(mk(0, 32'h10C, 1, 0, 0, 32'h0,         32'h00C00193, 0, 0, 32'h10C, 16'd6, 0));
        tbl.push_back(mk(0, 32'h10C, 0, 0, 0, 32'h0,         NOP,          1, 0, 32'h10C, 16'd6, 0));
        tbl.push_back(mk(0, 32'h10C, 0, 1, 0, 32'h0,         NOP,          1, 1, 32'h10C, 16'd7, 0));
        tbl.push_back(mk(0, 32'h10C, 0, 0, 1, 32'h00C00193,  NOP,          1, 0, 32'h10C, 16'd7, 0));
        tbl.push_back(mk(0, 32'h10C, 0, 0, 0, 32'h0,         32'h00C00193, 0, 0, 32'h10C, 16'd7, 0));
`ifdef IFU_MISALIGN_CHECK_EN
        // Unaligned PC traps: no request, no count change.
        tbl.push_back(mk(0, 32'h102, 0, 1, 0, 32'h0,         NOP,          0, 0, 32'h10C, 16'd7, 1));
        tbl.push_back(mk(0, 32'h102, 0, 1, 0, 32'h0,         NOP,          0, 0, 32'h10C, 16'd7, 1));
        tbl.push_back(mk(0, 32'h102, 0, 1, 0, 32'h0,         NOP,          0, 0, 32'h10C, 16'd7, 1));
        tbl.push_back(mk(0, 32'h10C, 0, 0, 0, 32'h0,         32'h00C00193, 0, 0, 32'h10C, 16'd7, 0));
`else
        // Unaligned PC fetches the containing word at 0x100.
        tbl.push_back(mk(0, 32'h102, 0, 0, 0, 32'h0,         NOP,          1, 0, 32'h10C, 16'd7, 0));
        tbl.push_back(mk(0, 32'h102, 0, 1, 0, 32'h0,         NOP,          1, 1, 32'h100, 16'd8, 0));
        tbl.push_back(mk(0, 32'h102, 0, 0, 1, 32'h00200213,  NOP,          1, 0, 32'h100, 16'd8, 0));
        tbl.push_back(mk(0, 32'h102, 0, 0, 0, 32'h0,         32'h00200213, 0, 0, 32'h100, 16'd8, 0));
        tbl.push_back(mk(0, 32'h100, 0, 0, 0, 32'h0,         32'h00200213, 0, 0, 32'h100, 16'd8, 0));
`endif

        // Reset state.
        step("reset0", mk(1, 32'h0, 0, 0, 0, 32'h0, NOP, 1, 0, 32'h0, 16'd0, 0));
        step("reset1", mk(1, 32'h0, 0, 0, 0, 32'h0, NOP, 1, 0, 32'h0, 16'd0, 0));

        // Reset mid-transaction, then a late rvalid that must not fill the buffer.
        step("rstw_miss", mk(0, 32'h200, 0, 1, 0, 32'h0,        NOP, 1, 0, 32'h000, 16'd0, 0));
        step("rstw_req",  mk(0, 32'h200, 0, 1, 0, 32'h0,        NOP, 1, 1, 32'h200, 16'd1, 0));
        step("rstw_rst",  mk(1, 32'h200, 0, 0, 0, 32'h0,        NOP, 1, 0, 32'h000, 16'd1, 0));
        step("rstw_late", mk(0, 32'h000, 0, 0, 1, 32'hDEADBEEF, NOP, 1, 0, 32'h000, 16'd0, 0));
        step("rstw_pc0",  mk(0, 32'h000, 0, 0, 1, 32'hDEADBEEF, NOP, 1, 1, 32'h000, 16'd1, 0));
        step("rst2a",     mk(1, 32'h000, 0, 0, 0, 32'h0,        NOP, 1, 0, 32'h000, 16'd1, 0));
        step("rst2b",     mk(1, 32'h000, 0, 0, 0, 32'h0,        NOP, 1, 0, 32'h000, 16'd0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
